// File: rtl/lvds_host_sched.sv
// lvds_host_sched: round-robin scheduler sharing one LVDS remote-IO host link.
// Serialises 40-bit command words onto the host write port, enforces a minimum
// spacing between commands, and for reads waits (with timeout) for the 32-bit
// response and routes it back to the requester that issued the read.
//
// Handshake: a requester raises req[i] (with req_rd[i] and its command word) and
// holds it until ack[i] pulses; ack marks the cycle the word is on host_wdata
// with host_wvalid. A read's result comes back as a one-cycle done[i] with dout
// and err. Requests still high during the ack cycle are eligible again later.
module lvds_host_sched #(
    parameter int NR      = 4,
    parameter int GAP     = 12,
    parameter int TIMEOUT = 255
) (
    input  logic             c,
    input  logic             r,
    input  logic [NR-1:0]    req,
    input  logic [NR-1:0]    req_rd,
    input  logic [40*NR-1:0] req_data,
    output logic [NR-1:0]    ack,
    output logic [NR-1:0]    done,
    output logic [31:0]      dout,
    output logic             err,
    output logic             busy,
    output logic             host_wvalid,
    output logic [39:0]      host_wdata,
    input  logic             host_rvalid,
    input  logic [31:0]      host_rdata
);
    localparam int PW = $clog2(NR);
    // Spacing counter only ever holds GAP-1 down to 0.
    localparam int SW = $clog2(GAP);

    typedef enum logic {
        S_IDLE,
        S_WAIT_RD
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_sp;
    logic [15:0]     r_tc;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_ptr_nxt;
    logic [SW-1:0]   w_sp_dec;
    logic            w_timeout;

    // Round-robin pick: first requester at or after r_ptr, wrapping modulo NR.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NR; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NR]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_ptr) + k) % NR);
            end
        end
    end

    // Pointer advance, saturating spacing decrement and read timeout detect.
    always_comb begin
        w_ptr_nxt = (int'(w_win) == NR - 1) ? '0 : w_win + 1'b1;
        w_sp_dec  = (r_sp != '0) ? r_sp - 1'b1 : '0;
        w_timeout = (r_tc == 16'(TIMEOUT - 1));
    end

    // Scheduler FSM with all outputs registered; busy tracks the next state/spacing.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            r_state     <= S_IDLE;
            r_sp        <= '0;
            r_tc        <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            ack         <= '0;
            done        <= '0;
            dout        <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            host_wvalid <= 1'b0;
            host_wdata  <= '0;
        end else begin
            ack         <= '0;
            done        <= '0;
            err         <= 1'b0;
            host_wvalid <= 1'b0;
            r_sp        <= w_sp_dec;
            case (r_state)
                S_IDLE: begin
                    // host_rvalid here is an orphan response and is ignored.
                    if (r_sp == '0 && w_found) begin
                        host_wvalid  <= 1'b1;
                        host_wdata   <= req_data[40*int'(w_win) +: 40];
                        ack[w_win]   <= 1'b1;
                        r_sp         <= SW'(GAP - 1);
                        r_owner      <= w_win;
                        r_ptr        <= w_ptr_nxt;
                        busy         <= 1'b1;
                        if (req_rd[w_win]) begin
                            r_state <= S_WAIT_RD;
                            r_tc    <= '0;
                        end
                    end else begin
                        busy <= (w_sp_dec != '0);
                    end
                end
                S_WAIT_RD: begin
                    r_tc <= r_tc + 1'b1;
                    // A response arriving on the timeout cycle still counts as good.
                    if (host_rvalid) begin
                        dout          <= host_rdata;
                        err           <= 1'b0;
                        done[r_owner] <= 1'b1;
                        r_state       <= S_IDLE;
                        busy          <= (w_sp_dec != '0);
                    end else if (w_timeout) begin
                        dout          <= 32'hFFFF_FFFF;
                        err           <= 1'b1;
                        done[r_owner] <= 1'b1;
                        r_state       <= S_IDLE;
                        busy          <= (w_sp_dec != '0);
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= (w_sp_dec != '0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_host_sched.sv
// Testbench for lvds_host_sched: reset checks, a round-robin vector table,
// hand-written multi-cycle sequences and a randomized run, all cross-checked
// cycle by cycle against a timestamp-based reference model.
module tb_lvds_host_sched;
    localparam int NR      = 4;
    localparam int GAP     = 12;
    localparam int TIMEOUT = 255;

    logic             c;
    logic             r;
    logic [NR-1:0]    req;
    logic [NR-1:0]    req_rd;
    logic [40*NR-1:0] req_data;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    done;
    logic [31:0]      dout;
    logic             err;
    logic             busy;
    logic             host_wvalid;
    logic [39:0]      host_wdata;
    logic             host_rvalid;
    logic [31:0]      host_rdata;

    lvds_host_sched #(.NR(NR), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .c(c), .r(r), .req(req), .req_rd(req_rd), .req_data(req_data),
        .ack(ack), .done(done), .dout(dout), .err(err), .busy(busy),
        .host_wvalid(host_wvalid), .host_wdata(host_wdata),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata)
    );

    // Clock and watchdog
    initial c = 1'b0;
    always #5 c = ~c;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard counters
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: timestamps of the last grant and of the outstanding read
    int            m_e, m_last_g, m_rd_edge, m_ptr, m_owner;
    bit            m_rd_out;
    logic [NR-1:0] x_ack, x_done;
    logic          x_wv, x_err, x_busy;
    logic [31:0]   x_dout;
    logic [39:0]   x_wdata;

    task automatic model_reset;
        m_e = 0; m_last_g = -GAP; m_rd_out = 0; m_rd_edge = 0; m_ptr = 0; m_owner = 0;
        x_ack = '0; x_done = '0; x_wv = 1'b0; x_err = 1'b0; x_busy = 1'b0;
        x_dout = '0; x_wdata = '0;
    endtask

    // Predicts outputs after the next edge from the inputs currently driven.
    task automatic model_edge;
        int w;
        m_e++;
        x_ack = '0; x_done = '0; x_wv = 1'b0; x_err = 1'b0;
        if (m_rd_out) begin
            if (host_rvalid) begin
                x_done[m_owner] = 1'b1; x_dout = host_rdata; x_err = 1'b0; m_rd_out = 0;
            end else if (m_e == m_rd_edge + TIMEOUT) begin
                x_done[m_owner] = 1'b1; x_dout = 32'hFFFF_FFFF; x_err = 1'b1; m_rd_out = 0;
            end
        end else if (m_e - m_last_g >= GAP && req != '0) begin
            w = -1;
            for (int k = 0; k < NR; k++)
                if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            x_wv = 1'b1;
            x_wdata = req_data[40*w +: 40];
            x_ack[w] = 1'b1;
            m_owner = w;
            m_ptr = (w + 1) % NR;
            m_last_g = m_e;
            if (req_rd[w]) begin
                m_rd_out = 1; m_rd_edge = m_e;
            end
        end
        x_busy = m_rd_out || (m_e - m_last_g < GAP - 1);
    endtask

    // Driver: advance one clock, then compare every output with the model.
    task automatic tick;
        model_edge();
        @(posedge c); #1;
        cyc++;
        chk("m_ack", 64'(ack), 64'(x_ack));
        chk("m_done", 64'(done), 64'(x_done));
        chk("m_wvalid", 64'(host_wvalid), 64'(x_wv));
        chk("m_busy", 64'(busy), 64'(x_busy));
        chk("m_dout", 64'(dout), 64'(x_dout));
        if (x_wv) chk("m_wdata", 64'(host_wdata), 64'(x_wdata));
        if (x_done != '0) chk("m_err", 64'(err), 64'(x_err));
    endtask

    task automatic do_reset;
        r = 1'b1; req = '0; req_rd = '0; req_data = '0; host_rvalid = 1'b0; host_rdata = '0;
        @(posedge c); #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wvalid", 64'(host_wvalid), 64'd0);
        chk("rst_wdata", 64'(host_wdata), 64'd0);
        r = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] exp_ack;
    } rr_vec_t;

    rr_vec_t     tbl [9];
    int          order [5];
    int          times [5];
    int          exp_order [5];
    int          g, cnt, gcount, d;
    logic [63:0] rnd;
    int          resp_at, sel;
    bit          resp_pend;

    initial begin
        // Round-robin table: pointer starts at 0 after reset and moves past each winner.
        tbl[0] = '{4'b1111, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010};
        tbl[2] = '{4'b1001, 4'b1000};
        tbl[3] = '{4'b1001, 4'b0001};
        tbl[4] = '{4'b0110, 4'b0010};
        tbl[5] = '{4'b0100, 4'b0100};
        tbl[6] = '{4'b0011, 4'b0001};
        tbl[7] = '{4'b1000, 4'b1000};
        tbl[8] = '{4'b1100, 4'b0100};
        exp_order = '{0, 1, 2, 3, 0};

        do_reset();

        // Table-driven arbitration vectors
        for (int i = 0; i < 9; i++) begin
            req = tbl[i].req;
            for (int j = 0; j < NR; j++) req_data[40*j +: 40] = {8'(j), 32'h0BAD_0000 + 32'(i)};
            tick();
            chk("rr_tbl_ack", 64'(ack), 64'(tbl[i].exp_ack));
            chk("rr_tbl_wvalid", 64'(host_wvalid), 64'd1);
            req = '0;
            repeat (GAP - 1) tick();
        end

        // Single write from requester 2
        do_reset();
        req = 4'b0100;
        req_data[80 +: 40] = 40'h12_3456_789A;
        tick();
        chk("wr_wvalid", 64'(host_wvalid), 64'd1);
        chk("wr_wdata", 64'(host_wdata), 64'h12_3456_789A);
        chk("wr_ack", 64'(ack), 64'b0100);
        req = '0;
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 40 && busy; i++) begin
            tick();
            if (busy) cnt++;
        end
        chk("wr_busy_len", 64'(cnt), 64'(GAP - 1));

        // Four continuous writers
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < NR; j++) req_data[40*j +: 40] = {8'hC0 + 8'(j), 32'h5A5A_0000 + 32'(j)};
        gcount = 0;
        for (int i = 0; i < 80 && gcount < 5; i++) begin
            tick();
            if (host_wvalid) begin
                order[gcount] = -1;
                for (int j = 0; j < NR; j++) if (ack[j]) order[gcount] = j;
                times[gcount] = cyc;
                gcount++;
            end
        end
        chk("cont_grants", 64'(gcount), 64'd5);
        for (int j = 0; j < 5; j++) chk("cont_order", 64'(order[j]), 64'(exp_order[j]));
        for (int j = 1; j < 5; j++) chk("cont_spacing", 64'(times[j] - times[j-1]), 64'(GAP));
        req = '0;

        // Read with a response 20 cycles after issue; requester 3 waits meanwhile
        do_reset();
        req = 4'b0010; req_rd = 4'b0010;
        req_data[40 +: 40] = 40'hAA_0000_0001;
        req_data[120 +: 40] = 40'hBB_0000_0003;
        tick();
        chk("rd_ack", 64'(ack), 64'b0010);
        g = cyc;
        req = 4'b1000; req_rd = 4'b0000;
        while (cyc < g + 19) begin
            tick();
            chk("rd_hold_ack", 64'(ack), 64'd0);
        end
        host_rvalid = 1'b1; host_rdata = 32'hDEAD_BEEF;
        tick();
        host_rvalid = 1'b0;
        chk("rd_done", 64'(done), 64'b0010);
        chk("rd_dout", 64'(dout), 64'hDEAD_BEEF);
        chk("rd_err", 64'(err), 64'd0);
        chk("rd_no_ack_at_done", 64'(ack), 64'd0);
        tick();
        chk("rd_next_ack", 64'(ack), 64'b1000);
        req = '0;

        // Read timeout with no response
        do_reset();
        req = 4'b0001; req_rd = 4'b0001;
        tick();
        g = cyc;
        req = '0; req_rd = '0;
        for (int i = 0; i < 300 && done == '0; i++) tick();
        d = cyc - g;
        chk("to_delay", 64'(d), 64'(TIMEOUT));
        chk("to_done", 64'(done), 64'b0001);
        chk("to_dout", 64'(dout), 64'hFFFF_FFFF);
        chk("to_err", 64'(err), 64'd1);

        // Response on the exact timeout cycle wins over the timeout
        req = 4'b0001; req_rd = 4'b0001;
        tick();
        chk("tor_ack", 64'(ack), 64'b0001);
        g = cyc;
        req = '0; req_rd = '0;
        while (cyc < g + TIMEOUT - 1) tick();
        host_rvalid = 1'b1; host_rdata = 32'hCAFE_F00D;
        tick();
        host_rvalid = 1'b0;
        chk("tor_done", 64'(done), 64'b0001);
        chk("tor_err", 64'(err), 64'd0);
        chk("tor_dout", 64'(dout), 64'hCAFE_F00D);
        // Orphan response while idle
        repeat (3) tick();
        host_rvalid = 1'b1; host_rdata = 32'h1111_1111;
        tick();
        host_rvalid = 1'b0;
        chk("orphan_done", 64'(done), 64'd0);
        chk("orphan_dout", 64'(dout), 64'hCAFE_F00D);
        tick();
        chk("orphan_done2", 64'(done), 64'd0);

        // Reset asserted in the middle of a read
        do_reset();
        req = 4'b0100; req_rd = 4'b0100;
        tick();
        req = '0; req_rd = '0;
        repeat (5) tick();
        #2 r = 1'b1;
        #1;
        chk("mrst_ack", 64'(ack), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_dout", 64'(dout), 64'd0);
        chk("mrst_err", 64'(err), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_wvalid", 64'(host_wvalid), 64'd0);
        chk("mrst_wdata", 64'(host_wdata), 64'd0);
        model_reset();
        req = 4'b1010;
        @(posedge c); #1;
        chk("mrst_done_held", 64'(done), 64'd0);
        chk("mrst_ack_held", 64'(ack), 64'd0);
        r = 1'b0;
        model_reset();
        tick();
        chk("mrst_first_grant", 64'(ack), 64'b0010);
        req = '0;

        // Randomized traffic checked against the model
        do_reset();
        resp_pend = 0;
        resp_at = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    rnd = {$urandom(), $urandom()};
                    req[i] = 1'b1;
                    req_rd[i] = ($urandom_range(0, 2) == 0);
                    req_data[40*i +: 40] = rnd[39:0];
                end else if (req[i] && $urandom_range(0, 99) == 0) begin
                    req[i] = 1'b0;
                end
            end
            host_rvalid = (resp_pend && cyc + 1 == resp_at) || ($urandom_range(0, 79) == 0);
            host_rdata = $urandom();
            if (resp_pend && cyc + 1 == resp_at) resp_pend = 0;
            tick();
            if (host_wvalid) begin
                for (int i = 0; i < NR; i++) begin
                    if (ack[i]) begin
                        if (req_rd[i]) begin
                            sel = $urandom_range(0, 9);
                            if (sel < 6) begin
                                resp_pend = 1; resp_at = cyc + $urandom_range(1, 30);
                            end else if (sel < 8) begin
                                resp_pend = 1; resp_at = cyc + TIMEOUT;
                            end else begin
                                resp_pend = 0;
                            end
                        end
                        req[i] = 1'b0;
                    end
                end
            end
        end
        host_rvalid = 1'b0;
        req = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lvds_host_sched.md
# lvds_host_sched

Round-robin scheduler sharing one LVDS remote-IO host link among NR requesters. It serialises 40-bit command words onto the host write port and enforces a minimum spacing between commands so the 42-bit serial frame completes. For read commands it waits for the returned 32-bit word, with a timeout, and routes it back to the originating requester. It sits between on-chip masters (register bus, sequencers) and the LVDS host link.

## Interface
- NR, 4: number of requesters (2..8).
- GAP, 12: minimum clock cycles between successive host_wvalid pulses (≥2).
- TIMEOUT, 255: cycles to wait for a read response before declaring an error (≥2, fits 16 bits).

Ports:
- c  input  1  clock.
- r  input  1  reset, asynchronous, active-high.
- req  input  NR  per-requester command request; held until ack.
- req_rd  input  NR  per-requester flag: the command expects a read response.
- req_data  input  40*NR  command words; requester i uses bits [40*i+39:40*i].
- ack  output  NR  one-cycle pulse: the command of requester i was issued.
- done  output  NR  one-cycle pulse: the read for requester i completed or timed out.
- dout  output  32  read data, valid with done.
- err  output  1  high with done when the read timed out.
- busy  output  1  high whenever state ≠ IDLE or the spacing counter ≠ 0.
- host_wvalid  output  1  one-cycle command strobe to the link transmitter.
- host_wdata  output  40  command word, valid with host_wvalid.
- host_rvalid  input  1  one-cycle strobe: a valid read response arrived (receiver valid with the frame's flag bit clear).
- host_rdata  input  32  response word, valid with host_rvalid.

## Operation
- All outputs are registered. Reset values: ack=0, done=0, dout=0, err=0, busy=0, host_wvalid=0, host_wdata=0. Reset also sets state=IDLE, spacing counter sp=0, timeout counter tc=0, RR pointer ptr=0, and owner=0.
- Arbitration uses round robin. Search starts at ptr and wraps modulo NR; the first i with req[i]=1 wins. After a grant, ptr = winner+1 mod NR.
- States:
  - IDLE: if sp==0 and any req, grant winner w. Next cycle: host_wvalid=1, host_wdata=req_data[w], ack[w]=1, sp=GAP-1, owner=w. If req_rd[w], go to WAIT_RD with tc=0; otherwise stay in IDLE. While sp≠0, decrement sp each cycle and make no grant.
  - WAIT_RD: sp keeps decrementing to 0. tc increments each cycle.
    - On host_rvalid: dout=host_rdata, err=0, done[owner]=1, go to IDLE.
    - Else if tc==TIMEOUT-1: dout=32'hFFFFFFFF, err=1, done[owner]=1, go to IDLE.
    - Further requests wait; at most one read is outstanding.
- host_rvalid in IDLE is a stale or orphan response and is ignored. dout is unchanged.
- Simultaneous host_rvalid and timeout in the same cycle: the response wins (err=0).
- A request dropped before ack is never issued. Requests still asserted during the ack cycle are sampled again and may be granted once spacing allows, so requesters drop req on ack.
- A return to IDLE from WAIT_RD with sp==0 allows a grant on the same edge as the first IDLE evaluation.
- Reset asserted mid-read: the outstanding read is abandoned with no done pulse, and all state returns to reset values immediately.

## Timing
- Grant latency: req[i] sampled high at edge k in IDLE with sp==0 gives host_wvalid and ack[i] high in the cycle following edge k (1 cycle).
- Write-only throughput: one command per GAP cycles, so host_wvalid rising edges are exactly GAP cycles apart under continuous requests.
- Read response latency: done is high in the cycle after the edge that samples host_rvalid.
- Timeout: done/err is high TIMEOUT cycles after the host_wvalid cycle of the read.
- Next issue after a read: max(GAP cycles after the previous wvalid, 1 cycle after done).
- ack, done, and host_wvalid are each high for exactly 1 cycle per event.

## Test plan
- Single write with NR=4: req[2]=1, req_rd=0, data=40'h12_3456_789A. Required: one cycle later host_wvalid=1, host_wdata=40'h123456789A, ack=4'b0100; busy stays high for GAP-1 further cycles.
- All four requesters write continuously with GAP=12. Required: grant order 0,1,2,3,0; wvalid pulses exactly 12 cycles apart; no requester is granted twice before another pending one.
- Read: req[1] with rd=1, then host_rvalid with rdata=32'hDEADBEEF 20 cycles after issue. Required: done=4'b0010, dout=32'hDEADBEEF, err=0; req[3] pending meanwhile is not issued until after done.
- Read timeout with TIMEOUT=255 and no rvalid. Required: done[owner] exactly 255 cycles after wvalid, dout=32'hFFFFFFFF, err=1.
- host_rvalid on the exact timeout cycle. Required: err=0 and dout=host_rdata. host_rvalid while in IDLE: dout unchanged, no done.
- Assert r during WAIT_RD. Required: all outputs 0 immediately, no done pulse, ptr=0, and the first grant after release goes to the lowest pending requester.
